// File: rtl/ex_mem_stage_pkg.sv
// Shared types for the EX/MEM stage: datapath widths, sequencer state encoding,
// the pipeline register layout and the timeout-counter width helper.
package ex_mem_stage_pkg;
  localparam int DW          = 16;
  localparam int RW          = 3;
  localparam int TIMEOUT_DEF = 64;

  typedef enum logic {
    S_IDLE = 1'b0,
    S_WAIT = 1'b1
  } state_e;

  typedef struct packed {
    logic [DW-1:0] alu_out;
    logic [DW-1:0] r2;
    logic [DW-1:0] pc_add2;
    logic [DW-1:0] instr;
    logic [RW-1:0] w1_reg;
    logic          reg_en;
    logic          mem_en;
    logic          mem_wr;
    logic          halt;
  } pipe_t;

  // CNT_W for a given timeout: wide enough to hold TIMEOUT itself.
  function automatic int cnt_w(input int timeout);
    return $clog2(timeout + 1);
  endfunction
endpackage

// File: rtl/ex_mem_stage_mem_seq.sv
// Data-cache access sequencer: one request per memory op, waits for done,
// abandons the access after TIMEOUT stalled cycles.
module ex_mem_stage_mem_seq
  import ex_mem_stage_pkg::*;
#(
  parameter int TIMEOUT = TIMEOUT_DEF
) (
  input  logic clk,
  input  logic rst,
  input  logic mem_en_i,
  input  logic cache_done_i,
  output logic stall_o,
  output logic cache_req_o,
  output logic complete_o,
  output logic timeout_o
);
  localparam int CNT_W = cnt_w(TIMEOUT);

  state_e           state_q;
  logic             svc_q;
  logic [CNT_W-1:0] cnt_q;
  logic             pend;
  logic             is_wait;

  assign pend        = mem_en_i & ~svc_q;
  assign is_wait     = (state_q == S_WAIT);
  assign cache_req_o = pend & ~is_wait;
  assign complete_o  = pend & cache_done_i;
  assign stall_o     = pend & ~cache_done_i;
  // The idle miss cycle is counted too, so the total stall is TIMEOUT cycles.
  assign timeout_o   = is_wait & stall_o & (cnt_q == CNT_W'(TIMEOUT - 1));

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= S_IDLE;
      svc_q   <= 1'b0;
      cnt_q   <= '0;
    end else begin
      if (!stall_o)        svc_q <= 1'b0;
      else if (complete_o) svc_q <= 1'b1;
      case (state_q)
        S_IDLE: begin
          if (stall_o) begin
            state_q <= S_WAIT;
            cnt_q   <= cnt_q + 1'b1;
          end
        end
        S_WAIT: begin
          if (complete_o || timeout_o) begin
            state_q <= S_IDLE;
            cnt_q   <= '0;
          end else begin
            cnt_q <= cnt_q + 1'b1;
          end
        end
        default: state_q <= S_IDLE;
      endcase
    end
  end
endmodule

// File: rtl/ex_mem_stage.sv
// EX/MEM pipeline register with bubble insert and data-cache sequencing;
// stall_out freezes upstream and this register while a miss is outstanding.
module ex_mem_stage
  import ex_mem_stage_pkg::*;
#(
  parameter int TIMEOUT = TIMEOUT_DEF
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          flush,
  input  logic [DW-1:0] alu_out,
  input  logic [DW-1:0] r2_fwd,
  input  logic [RW-1:0] w1_reg_ID_EX,
  input  logic          reg_en_ID_EX,
  input  logic          mem_en_ID_EX,
  input  logic          mem_wr_ID_EX,
  input  logic          halt_ID_EX,
  input  logic [DW-1:0] pc_add2_ID_EX,
  input  logic [DW-1:0] instr_ID_EX,
  input  logic          cache_done,
  input  logic [DW-1:0] cache_rdata,
  output logic          cache_req,
  output logic          cache_wr,
  output logic [DW-1:0] cache_addr,
  output logic [DW-1:0] cache_wdata,
  output logic          stall_out,
  output logic [DW-1:0] alu_out_EX_MEM,
  output logic [DW-1:0] r2_EX_MEM,
  output logic [RW-1:0] w1_reg_EX_MEM,
  output logic          reg_en_EX_MEM,
  output logic          mem_en_EX_MEM,
  output logic          mem_wr_EX_MEM,
  output logic          halt_EX_MEM,
  output logic [DW-1:0] pc_add2_EX_MEM,
  output logic [DW-1:0] instr_EX_MEM,
  output logic [DW-1:0] mem_rdata_EX_MEM,
  output logic          mem_err
);
  pipe_t         pipe_q, pipe_d, pipe_in;
  logic [DW-1:0] rdata_q, rdata_d;
  logic          err_q, err_d;
  logic          load, complete, timeout;

  ex_mem_stage_mem_seq #(.TIMEOUT(TIMEOUT)) u_mem_seq (
    .clk         (clk),
    .rst         (rst),
    .mem_en_i    (pipe_q.mem_en),
    .cache_done_i(cache_done),
    .stall_o     (stall_out),
    .cache_req_o (cache_req),
    .complete_o  (complete),
    .timeout_o   (timeout)
  );

  assign load    = ~stall_out;
  assign pipe_in = '{alu_out: alu_out, r2: r2_fwd, pc_add2: pc_add2_ID_EX,
                     instr: instr_ID_EX, w1_reg: w1_reg_ID_EX, reg_en: reg_en_ID_EX,
                     mem_en: mem_en_ID_EX, mem_wr: mem_wr_ID_EX, halt: halt_ID_EX};

  always_comb begin
    pipe_d  = pipe_q;
    rdata_d = rdata_q;
    err_d   = err_q | timeout;
    if (load) begin
      pipe_d = flush ? '0 : pipe_in;
    end else if (timeout) begin
      // Abandoned access: the op must neither write back nor be re-issued.
      pipe_d.reg_en = 1'b0;
      pipe_d.mem_en = 1'b0;
    end
    if (complete && !pipe_q.mem_wr) rdata_d = cache_rdata;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pipe_q  <= '0;
      rdata_q <= '0;
      err_q   <= 1'b0;
    end else begin
      pipe_q  <= pipe_d;
      rdata_q <= rdata_d;
      err_q   <= err_d;
    end
  end

  assign cache_wr         = pipe_q.mem_wr;
  assign cache_addr       = pipe_q.alu_out;
  assign cache_wdata      = pipe_q.r2;
  assign alu_out_EX_MEM   = pipe_q.alu_out;
  assign r2_EX_MEM        = pipe_q.r2;
  assign w1_reg_EX_MEM    = pipe_q.w1_reg;
  assign reg_en_EX_MEM    = pipe_q.reg_en;
  assign mem_en_EX_MEM    = pipe_q.mem_en;
  assign mem_wr_EX_MEM    = pipe_q.mem_wr;
  assign halt_EX_MEM      = pipe_q.halt;
  assign pc_add2_EX_MEM   = pipe_q.pc_add2;
  assign instr_EX_MEM     = pipe_q.instr;
  assign mem_rdata_EX_MEM = rdata_q;
  assign mem_err          = err_q;
endmodule

// File: tb/tb_ex_mem_stage.sv
// Bench for ex_mem_stage with TIMEOUT=8: scoreboard of expected EX_MEM contents,
// one task per scenario.
module tb_ex_mem_stage;
  logic        clk = 1'b0;
  logic        rst, flush;
  logic [15:0] alu_out, r2_fwd, pc_add2_ID_EX, instr_ID_EX, cache_rdata;
  logic [2:0]  w1_reg_ID_EX;
  logic        reg_en_ID_EX, mem_en_ID_EX, mem_wr_ID_EX, halt_ID_EX, cache_done;
  logic        cache_req, cache_wr, stall_out, mem_err;
  logic [15:0] cache_addr, cache_wdata, alu_out_EX_MEM, r2_EX_MEM, pc_add2_EX_MEM;
  logic [15:0] instr_EX_MEM, mem_rdata_EX_MEM;
  logic [2:0]  w1_reg_EX_MEM;
  logic        reg_en_EX_MEM, mem_en_EX_MEM, mem_wr_EX_MEM, halt_EX_MEM;

  int checks = 0;
  int failures = 0;
  logic [70:0] sb[$];
  logic [70:0] obs_pipe, exp_pipe;

  assign obs_pipe = {alu_out_EX_MEM, r2_EX_MEM, pc_add2_EX_MEM, instr_EX_MEM, w1_reg_EX_MEM,
                     reg_en_EX_MEM, mem_en_EX_MEM, mem_wr_EX_MEM, halt_EX_MEM};

  always #5 clk = ~clk;

  ex_mem_stage #(.TIMEOUT(8)) dut (
    .clk(clk), .rst(rst), .flush(flush), .alu_out(alu_out), .r2_fwd(r2_fwd),
    .w1_reg_ID_EX(w1_reg_ID_EX), .reg_en_ID_EX(reg_en_ID_EX), .mem_en_ID_EX(mem_en_ID_EX),
    .mem_wr_ID_EX(mem_wr_ID_EX), .halt_ID_EX(halt_ID_EX), .pc_add2_ID_EX(pc_add2_ID_EX),
    .instr_ID_EX(instr_ID_EX), .cache_done(cache_done), .cache_rdata(cache_rdata),
    .cache_req(cache_req), .cache_wr(cache_wr), .cache_addr(cache_addr),
    .cache_wdata(cache_wdata), .stall_out(stall_out), .alu_out_EX_MEM(alu_out_EX_MEM),
    .r2_EX_MEM(r2_EX_MEM), .w1_reg_EX_MEM(w1_reg_EX_MEM), .reg_en_EX_MEM(reg_en_EX_MEM),
    .mem_en_EX_MEM(mem_en_EX_MEM), .mem_wr_EX_MEM(mem_wr_EX_MEM), .halt_EX_MEM(halt_EX_MEM),
    .pc_add2_EX_MEM(pc_add2_EX_MEM), .instr_EX_MEM(instr_EX_MEM),
    .mem_rdata_EX_MEM(mem_rdata_EX_MEM), .mem_err(mem_err)
  );

  function automatic logic [70:0] mk(input logic [15:0] a, input logic [15:0] r2,
                                     input logic [2:0] w, input logic re, input logic me,
                                     input logic mw, input logic h);
    return {a, r2, a + 16'd2, a ^ 16'hA5A5, w, re, me, mw, h};
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Present an instruction to the stage and record what EX_MEM must hold once it loads.
  task automatic drive(input logic [70:0] v, input logic fl);
    {alu_out, r2_fwd, pc_add2_ID_EX, instr_ID_EX, w1_reg_ID_EX,
     reg_en_ID_EX, mem_en_ID_EX, mem_wr_ID_EX, halt_ID_EX} = v;
    flush = fl;
    sb.push_back(fl ? 71'd0 : v);
  endtask

  task automatic drive_nop();
    {alu_out, r2_fwd, pc_add2_ID_EX, instr_ID_EX, w1_reg_ID_EX,
     reg_en_ID_EX, mem_en_ID_EX, mem_wr_ID_EX, halt_ID_EX} = '0;
    flush = 1'b0;
  endtask

  // Hold cache_done low until cycle done_at (-1 = never); bounded by 20 cycles.
  task automatic run_miss(input int done_at, output int stalls, output int reqs,
                          output int changes);
    logic [70:0] held;
    held = obs_pipe;
    stalls = 0; reqs = 0; changes = 0;
    for (int c = 0; c < 20; c++) begin
      cache_done = (c == done_at);
      #1;
      if (cache_req) reqs++;
      if (!stall_out) break;
      stalls++;
      if (obs_pipe !== held) changes++;
      @(posedge clk);
      #1;
    end
  endtask

  task automatic test_reset();
    rst = 1'b0;
    drive_nop();
    cache_done = 1'b0; cache_rdata = '0;
    #1 rst = 1'b1;
    #2;
    checks++; if (obs_pipe !== 71'd0) begin failures++; $display("FAIL reset_pipe got=%h exp=0", obs_pipe); end
    checks++; if ({stall_out, cache_req, mem_err} !== 3'b000) begin failures++; $display("FAIL reset_ctl got=%b exp=000", {stall_out, cache_req, mem_err}); end
    checks++; if (mem_rdata_EX_MEM !== 16'h0) begin failures++; $display("FAIL reset_rdata got=%h exp=0", mem_rdata_EX_MEM); end
    #8 rst = 1'b0;
    tick();
  endtask

  task automatic test_alu_op();
    drive(mk(16'h1234, 16'h0007, 3'd1, 1'b1, 1'b0, 1'b0, 1'b1), 1'b0);
    tick();
    exp_pipe = sb.pop_front();
    checks++; if (obs_pipe !== exp_pipe) begin failures++; $display("FAIL alu_pipe got=%h exp=%h", obs_pipe, exp_pipe); end
    checks++; if ({stall_out, cache_req} !== 2'b00) begin failures++; $display("FAIL alu_stall got=%b exp=00", {stall_out, cache_req}); end
  endtask

  task automatic test_load_hit();
    drive(mk(16'h0040, 16'h0000, 3'd2, 1'b1, 1'b1, 1'b0, 1'b0), 1'b0);
    tick();
    exp_pipe = sb.pop_front();
    checks++; if (obs_pipe !== exp_pipe) begin failures++; $display("FAIL hit_pipe got=%h exp=%h", obs_pipe, exp_pipe); end
    drive_nop();
    cache_done = 1'b1; cache_rdata = 16'hBEEF;
    #1;
    checks++; if ({cache_req, stall_out, cache_wr} !== 3'b100) begin failures++; $display("FAIL hit_req got=%b exp=100", {cache_req, stall_out, cache_wr}); end
    checks++; if (cache_addr !== 16'h0040) begin failures++; $display("FAIL hit_addr got=%h exp=0040", cache_addr); end
    tick();
    cache_done = 1'b0;
    #1;
    checks++; if (mem_rdata_EX_MEM !== 16'hBEEF) begin failures++; $display("FAIL hit_rdata got=%h exp=BEEF", mem_rdata_EX_MEM); end
    checks++; if (cache_req !== 1'b0) begin failures++; $display("FAIL hit_single_req got=%b exp=0", cache_req); end
  endtask

  task automatic test_store_miss();
    int stalls, reqs, changes;
    drive(mk(16'h0100, 16'h00AA, 3'd3, 1'b0, 1'b1, 1'b1, 1'b0), 1'b0);
    tick();
    exp_pipe = sb.pop_front();
    checks++; if (obs_pipe !== exp_pipe) begin failures++; $display("FAIL st_pipe got=%h exp=%h", obs_pipe, exp_pipe); end
    checks++; if ({cache_wr, cache_wdata} !== {1'b1, 16'h00AA}) begin failures++; $display("FAIL st_wr got=%b/%h exp=1/00aa", cache_wr, cache_wdata); end
    drive(mk(16'h5555, 16'h0001, 3'd6, 1'b1, 1'b0, 1'b0, 1'b0), 1'b0);
    cache_rdata = 16'hDEAD;
    run_miss(5, stalls, reqs, changes);
    checks++; if (stalls !== 5) begin failures++; $display("FAIL st_stall_cycles got=%0d exp=5", stalls); end
    checks++; if (reqs !== 1) begin failures++; $display("FAIL st_req_pulses got=%0d exp=1", reqs); end
    checks++; if (changes !== 0) begin failures++; $display("FAIL st_held got=%0d exp=0", changes); end
    tick();
    cache_done = 1'b0;
    exp_pipe = sb.pop_front();
    checks++; if (obs_pipe !== exp_pipe) begin failures++; $display("FAIL st_next_pipe got=%h exp=%h", obs_pipe, exp_pipe); end
    checks++; if (mem_rdata_EX_MEM !== 16'hBEEF) begin failures++; $display("FAIL st_rdata_hold got=%h exp=BEEF", mem_rdata_EX_MEM); end
  endtask

  task automatic test_done_at_timeout();
    int stalls, reqs, changes;
    drive(mk(16'h0180, 16'h0000, 3'd7, 1'b1, 1'b1, 1'b0, 1'b0), 1'b0);
    tick();
    void'(sb.pop_front());
    drive_nop();
    cache_rdata = 16'h4242;
    run_miss(7, stalls, reqs, changes);
    checks++; if (stalls !== 7) begin failures++; $display("FAIL edge_stall_cycles got=%0d exp=7", stalls); end
    tick();
    cache_done = 1'b0;
    checks++; if ({mem_err, mem_rdata_EX_MEM} !== {1'b0, 16'h4242}) begin failures++; $display("FAIL edge_done_wins got=%b/%h exp=0/4242", mem_err, mem_rdata_EX_MEM); end
  endtask

  task automatic test_timeout();
    int stalls, reqs, changes;
    drive(mk(16'h0200, 16'h0000, 3'd4, 1'b1, 1'b1, 1'b0, 1'b0), 1'b0);
    tick();
    exp_pipe = sb.pop_front();
    checks++; if (obs_pipe !== exp_pipe) begin failures++; $display("FAIL to_pipe got=%h exp=%h", obs_pipe, exp_pipe); end
    drive(mk(16'h7777, 16'h0002, 3'd5, 1'b1, 1'b0, 1'b0, 1'b0), 1'b0);
    run_miss(-1, stalls, reqs, changes);
    checks++; if (stalls !== 8) begin failures++; $display("FAIL to_stall_cycles got=%0d exp=8", stalls); end
    checks++; if (reqs !== 1) begin failures++; $display("FAIL to_req_pulses got=%0d exp=1", reqs); end
    checks++; if ({mem_err, reg_en_EX_MEM, mem_en_EX_MEM} !== 3'b100) begin failures++; $display("FAIL to_drop got=%b exp=100", {mem_err, reg_en_EX_MEM, mem_en_EX_MEM}); end
    tick();
    exp_pipe = sb.pop_front();
    checks++; if (obs_pipe !== exp_pipe) begin failures++; $display("FAIL to_resume got=%h exp=%h", obs_pipe, exp_pipe); end
    checks++; if (mem_err !== 1'b1) begin failures++; $display("FAIL to_sticky got=%b exp=1", mem_err); end
  endtask

  task automatic test_flush();
    drive(mk(16'h0300, 16'h0033, 3'd1, 1'b1, 1'b1, 1'b0, 1'b1), 1'b1);
    tick();
    flush = 1'b0;
    exp_pipe = sb.pop_front();
    #1;
    checks++; if (obs_pipe !== exp_pipe) begin failures++; $display("FAIL fl_bubble got=%h exp=%h", obs_pipe, exp_pipe); end
    checks++; if ({cache_req, stall_out} !== 2'b00) begin failures++; $display("FAIL fl_noreq got=%b exp=00", {cache_req, stall_out}); end
    drive(mk(16'h0400, 16'h0000, 3'd5, 1'b1, 1'b1, 1'b0, 1'b0), 1'b0);
    tick();
    void'(sb.pop_front());
    drive(mk(16'h0808, 16'h0011, 3'd2, 1'b1, 1'b0, 1'b0, 1'b0), 1'b0);
    cache_rdata = 16'h0404;
    for (int c = 0; c < 4; c++) begin
      cache_done = (c == 3);
      flush = (c == 1);
      #1;
      checks++; if (stall_out !== (c < 3)) begin failures++; $display("FAIL fl_stall_c%0d got=%b exp=%b", c, stall_out, c < 3); end
      if (c < 3) @(posedge clk);
      if (c < 3) #1;
    end
    tick();
    cache_done = 1'b0;
    exp_pipe = sb.pop_front();
    checks++; if (obs_pipe !== exp_pipe) begin failures++; $display("FAIL fl_midstall got=%h exp=%h", obs_pipe, exp_pipe); end
  endtask

  task automatic test_back_to_back();
    drive(mk(16'h0010, 16'h0000, 3'd1, 1'b1, 1'b1, 1'b0, 1'b0), 1'b0);
    tick();
    void'(sb.pop_front());
    drive(mk(16'h0020, 16'h0000, 3'd2, 1'b1, 1'b1, 1'b0, 1'b0), 1'b0);
    cache_done = 1'b1; cache_rdata = 16'h1111;
    #1;
    checks++; if ({cache_req, cache_addr} !== {1'b1, 16'h0010}) begin failures++; $display("FAIL b2b_req_a got=%b/%h exp=1/0010", cache_req, cache_addr); end
    tick();
    exp_pipe = sb.pop_front();
    checks++; if (obs_pipe !== exp_pipe) begin failures++; $display("FAIL b2b_pipe_b got=%h exp=%h", obs_pipe, exp_pipe); end
    cache_rdata = 16'h2222;
    drive_nop();
    #1;
    checks++; if ({cache_req, cache_addr, stall_out} !== {1'b1, 16'h0020, 1'b0}) begin failures++; $display("FAIL b2b_req_b got=%b/%h/%b exp=1/0020/0", cache_req, cache_addr, stall_out); end
    checks++; if (mem_rdata_EX_MEM !== 16'h1111) begin failures++; $display("FAIL b2b_rdata_a got=%h exp=1111", mem_rdata_EX_MEM); end
    tick();
    cache_done = 1'b0;
    checks++; if (mem_rdata_EX_MEM !== 16'h2222) begin failures++; $display("FAIL b2b_rdata_b got=%h exp=2222", mem_rdata_EX_MEM); end
  endtask

  task automatic test_async_reset();
    drive(mk(16'h0500, 16'h0000, 3'd3, 1'b1, 1'b1, 1'b0, 1'b0), 1'b0);
    tick();
    void'(sb.pop_front());
    drive_nop();
    tick();
    tick();
    checks++; if (stall_out !== 1'b1) begin failures++; $display("FAIL ar_in_wait got=%b exp=1", stall_out); end
    #2 rst = 1'b1;
    #1;
    checks++; if (obs_pipe !== 71'd0) begin failures++; $display("FAIL ar_pipe got=%h exp=0", obs_pipe); end
    checks++; if ({stall_out, cache_req, mem_err} !== 3'b000) begin failures++; $display("FAIL ar_ctl got=%b exp=000", {stall_out, cache_req, mem_err}); end
    checks++; if (mem_rdata_EX_MEM !== 16'h0) begin failures++; $display("FAIL ar_rdata got=%h exp=0", mem_rdata_EX_MEM); end
    #1 rst = 1'b0;
    tick();
    drive(mk(16'h0600, 16'h0000, 3'd4, 1'b1, 1'b1, 1'b0, 1'b0), 1'b0);
    tick();
    exp_pipe = sb.pop_front();
    drive_nop();
    #1;
    checks++; if (obs_pipe !== exp_pipe) begin failures++; $display("FAIL ar_post_pipe got=%h exp=%h", obs_pipe, exp_pipe); end
    checks++; if ({cache_req, stall_out} !== 2'b11) begin failures++; $display("FAIL ar_fresh_req got=%b exp=11", {cache_req, stall_out}); end
    cache_done = 1'b1; cache_rdata = 16'h6060;
    #1;
    checks++; if (stall_out !== 1'b0) begin failures++; $display("FAIL ar_done got=%b exp=0", stall_out); end
    tick();
    cache_done = 1'b0;
    checks++; if (mem_rdata_EX_MEM !== 16'h6060) begin failures++; $display("FAIL ar_rdata_post got=%h exp=6060", mem_rdata_EX_MEM); end
  endtask

  initial begin
    test_reset();
    test_alu_op();
    test_load_hit();
    test_store_miss();
    test_done_at_timeout();
    test_timeout();
    test_flush();
    test_back_to_back();
    test_async_reset();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #50000;
    $display("FAIL watchdog expired");
    $fatal(1, "watchdog");
  end
endmodule
